// File: rtl/maclaurin_eval.sv
// Multi-function Maclaurin-series evaluator (tanh, sinh, sin, exp) using Horner's rule
// over a per-mode coefficient ROM, with saturating arithmetic and a sticky overflow flag.
module maclaurin_eval #(
  parameter int XW    = 17,
  parameter int FRAC  = 14,
  parameter int RW    = 32,
  parameter int TERMS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic signed [XW-1:0] data_x,
  output logic                 busy,
  output logic                 done,
  output logic signed [RW-1:0] result,
  output logic                 ovf
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SQUARE = 3'd1;
  localparam logic [2:0] S_HORNER = 3'd2;
  localparam logic [2:0] S_FINAL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] M_EXP = 2'd3;

  localparam logic signed [RW-1:0]   MAX_RW = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0]   MIN_RW = {1'b1, {(RW-1){1'b0}}};
  localparam logic signed [2*RW-1:0] MAX_P  = {{(RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [2*RW-1:0] MIN_P  = {{(RW+1){1'b1}}, {(RW-1){1'b0}}};

  function automatic longint fact(input int n);
    longint f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

  // Exact rational num/den rounded to nearest in Q.FRAC, clipped to XW bits.
  function automatic logic signed [XW-1:0] coef_of(input int m, input int k);
    longint num, den, mag, q, lim;
    num = 1;
    den = 1;
    case (m)
      0: begin
        case (k)
          0: begin num = 1;       den = 1;         end
          1: begin num = -1;      den = 3;         end
          2: begin num = 2;       den = 15;        end
          3: begin num = -17;     den = 315;       end
          4: begin num = 62;      den = 2835;      end
          5: begin num = -1382;   den = 155925;    end
          6: begin num = 21844;   den = 6081075;   end
          default: begin num = -929569; den = 638512875; end
        endcase
      end
      1: begin num = 1; den = fact(2*k+1); end
      2: begin num = ((k % 2) != 0) ? -1 : 1; den = fact(2*k+1); end
      default: begin num = 1; den = fact(k); end
    endcase
    mag = ((num < 0) ? -num : num) <<< FRAC;
    q   = (mag + den / 2) / den;
    if (num < 0) q = -q;
    lim = longint'(1) <<< (XW - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
    return q[XW-1:0];
  endfunction

  logic signed [XW-1:0] rom [4][8];

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    for (genvar gj = 0; gj < 8; gj++) begin : g_term
      assign rom[gi][gj] = coef_of(gi, gj);
    end
  end

  logic [2:0]           state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic signed [XW-1:0] x_q, x_d;
  logic signed [RW-1:0] acc_q, acc_d;
  logic signed [RW-1:0] z_q, z_d;
  logic [2:0]           k_q, k_d;
  logic                 sat_q, sat_d;
  logic signed [RW-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic signed [RW-1:0]   x_ext, mul_a, mul_b, mul_res, add_res;
  logic signed [2*RW-1:0] a_w, b_w, prod, prod_sh;
  logic signed [RW:0]     sum;
  logic signed [XW-1:0]   coef, coef_init;
  logic                   mul_ovf, add_ovf, sat_step;

  assign x_ext     = {{(RW-XW){x_q[XW-1]}}, x_q};
  assign coef      = rom[mode_q][k_q];
  assign coef_init = rom[mode][3'(TERMS-1)];

  // One shared multiplier; its operands depend on which step is running.
  always_comb begin
    mul_a = acc_q;
    mul_b = z_q;
    case (state_q)
      S_SQUARE: begin mul_a = x_ext; mul_b = x_ext; end
      S_FINAL:  begin mul_a = acc_q; mul_b = x_ext; end
      default:  begin mul_a = acc_q; mul_b = z_q;   end
    endcase
    a_w     = {{RW{mul_a[RW-1]}}, mul_a};
    b_w     = {{RW{mul_b[RW-1]}}, mul_b};
    prod    = a_w * b_w;
    prod_sh = prod >>> FRAC;
    mul_ovf = 1'b0;
    if (prod_sh > MAX_P) begin
      mul_res = MAX_RW;
      mul_ovf = 1'b1;
    end else if (prod_sh < MIN_P) begin
      mul_res = MIN_RW;
      mul_ovf = 1'b1;
    end else begin
      mul_res = prod_sh[RW-1:0];
    end
    sum     = {mul_res[RW-1], mul_res} + {{(RW+1-XW){coef[XW-1]}}, coef};
    add_ovf = sum[RW] ^ sum[RW-1];
    if (add_ovf) add_res = sum[RW] ? MIN_RW : MAX_RW;
    else         add_res = sum[RW-1:0];
    sat_step = sat_q | mul_ovf | add_ovf;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    acc_d    = acc_q;
    z_d      = z_q;
    k_d      = k_q;
    sat_d    = sat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          x_d    = data_x;
          acc_d  = {{(RW-XW){coef_init[XW-1]}}, coef_init};
          k_d    = 3'(TERMS - 2);
          sat_d  = 1'b0;
          if (mode == M_EXP) begin
            z_d     = {{(RW-XW){data_x[XW-1]}}, data_x};
            state_d = S_HORNER;
          end else begin
            state_d = S_SQUARE;
          end
        end
      end
      S_SQUARE: begin
        z_d     = mul_res;
        sat_d   = sat_q | mul_ovf;
        state_d = S_HORNER;
      end
      S_HORNER: begin
        acc_d = add_res;
        sat_d = sat_step;
        k_d   = k_q - 3'd1;
        if (k_q == 3'd0) begin
          if (mode_q == M_EXP) begin
            result_d = add_res;
            ovf_d    = sat_step;
            state_d  = S_DONE;
          end else begin
            state_d  = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        result_d = mul_res;
        ovf_d    = sat_q | mul_ovf;
        sat_d    = sat_q | mul_ovf;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      x_q      <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      k_q      <= 3'd0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      k_q      <= k_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_SQUARE) || (state_q == S_HORNER) || (state_q == S_FINAL);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_maclaurin_eval.sv
// Randomised self-checking bench for maclaurin_eval: default, RW=18 and TERMS=2 instances
// are checked against a real-valued-coefficient fixed-point series model.
module tb_maclaurin_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start0 = 0, start1 = 0, start2 = 0;
  logic [1:0]         mode0 = 0, mode1 = 0, mode2 = 0;
  logic signed [16:0] x0 = 0, x1 = 0, x2 = 0;
  logic               busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic signed [31:0] result0, result2;
  logic signed [17:0] result1;

  int checks = 0;
  int errors = 0;
  bit m_sat;

  maclaurin_eval u_dut (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .data_x(x0),
    .busy(busy0), .done(done0), .result(result0), .ovf(ovf0));

  maclaurin_eval #(.RW(18)) u_rw18 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .data_x(x1),
    .busy(busy1), .done(done1), .result(result1), .ovf(ovf1));

  maclaurin_eval #(.TERMS(2)) u_t2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .data_x(x2),
    .busy(busy2), .done(done2), .result(result2), .ovf(ovf2));

  // ---------------- reference model ----------------
  function automatic real rfact(input int n);
    real f = 1.0;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  function automatic longint ref_coef(input int m, input int k);
    real c;
    real tanh_c [8] = '{1.0, -1.0/3.0, 2.0/15.0, -17.0/315.0, 62.0/2835.0,
                        -1382.0/155925.0, 21844.0/6081075.0, -929569.0/638512875.0};
    case (m)
      0: c = tanh_c[k];
      1: c = 1.0 / rfact(2*k+1);
      2: c = (((k % 2) != 0) ? -1.0 : 1.0) / rfact(2*k+1);
      default: c = 1.0 / rfact(k);
    endcase
    if (c >= 0.0) return longint'($rtoi(c * 16384.0 + 0.5));
    return -longint'($rtoi(-c * 16384.0 + 0.5));
  endfunction

  function automatic longint clip(input longint v, input int rw);
    longint lim = longint'(1) <<< (rw - 1);
    if (v > lim - 1) begin m_sat = 1; return lim - 1; end
    if (v < -lim)    begin m_sat = 1; return -lim; end
    return v;
  endfunction

  function automatic longint rmul(input longint a, input longint b, input int rw);
    return clip((a * b) >>> 14, rw);
  endfunction

  task automatic model(input int m, input longint x, input int terms, input int rw,
                       output longint res, output bit ov);
    longint z, acc;
    m_sat = 0;
    z = (m == 3) ? x : rmul(x, x, rw);
    acc = ref_coef(m, terms - 1);
    for (int k = terms - 2; k >= 0; k--) acc = clip(rmul(acc, z, rw) + ref_coef(m, k), rw);
    if (m != 3) acc = rmul(acc, x, rw);
    res = acc;
    ov  = m_sat;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int sel, input bit s, input int m, input longint x);
    logic signed [16:0] xv;
    xv = x[16:0];
    case (sel)
      0: begin start0 = s; mode0 = 2'(m); x0 = xv; end
      1: begin start1 = s; mode1 = 2'(m); x1 = xv; end
      default: begin start2 = s; mode2 = 2'(m); x2 = xv; end
    endcase
  endtask

  function automatic bit dn(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  task automatic run(input int sel, input int m, input longint x,
                     output longint res, output bit ov, output int edges);
    bit got = 0;
    @(negedge clk);
    drive(sel, 1, m, x);
    @(posedge clk);
    #1 drive(sel, 0, 0, 0);
    edges = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1 edges++;
      if (dn(sel)) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout inst=%0d mode=%0d x=%0d: no done within 40 edges", sel, m, x);
    end
    res = (sel == 0) ? longint'(result0) : (sel == 1) ? longint'(result1) : longint'(result2);
    ov  = (sel == 0) ? ovf0 : (sel == 1) ? ovf1 : ovf2;
    $display("txn inst=%0d mode=%0d x=%0d -> result=%0d ovf=%0d edges=%0d", sel, m, x, res, ov, edges);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, ovf0, busy1, done1, busy2, done2} !== 7'b0 || result0 !== 0 || result1 !== 0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b ovf=%b result=%0d required all zero", busy0, done0, ovf0, result0);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_half();
    int     exp_r [4] = '{7571, 8538, 7855, 27013};
    int     exp_e [4] = '{9, 9, 9, 7};
    longint res, mres;
    bit     ov, mov;
    int     ed;
    for (int m = 0; m < 4; m++) begin
      run(0, m, 8192, res, ov, ed);
      model(m, 8192, 8, 32, mres, mov);
      checks++;
      if (res < exp_r[m] - 4 || res > exp_r[m] + 4 || ov !== 1'b0) begin
        errors++;
        $display("FAIL half_value mode=%0d result=%0d ovf=%0d required %0d+-4 ovf=0", m, res, ov, exp_r[m]);
      end
      checks++;
      if (res !== mres) begin
        errors++;
        $display("FAIL half_model mode=%0d result=%0d required %0d", m, res, mres);
      end
      checks++;
      if (ed !== exp_e[m]) begin
        errors++;
        $display("FAIL half_latency mode=%0d edges=%0d required %0d", m, ed, exp_e[m]);
      end
    end
  endtask

  task automatic test_zero_and_sign();
    longint res;
    bit     ov;
    int     ed;
    for (int m = 0; m < 4; m++) begin
      run(0, m, 0, res, ov, ed);
      checks++;
      if (res !== ((m == 3) ? 64'sd16384 : 64'sd0) || ov !== 1'b0) begin
        errors++;
        $display("FAIL zero_input mode=%0d result=%0d ovf=%0d required %0d ovf=0", m, res, ov, (m == 3) ? 16384 : 0);
      end
    end
    run(0, 0, -8192, res, ov, ed);
    checks++;
    if (res < -7575 || res > -7567 || ov !== 1'b0) begin
      errors++;
      $display("FAIL tanh_negative result=%0d ovf=%0d required -7571+-4 ovf=0", res, ov);
    end
  endtask

  task automatic test_random();
    longint res, mres, x;
    bit     ov, mov;
    int     ed, m;
    for (int n = 0; n < 24; n++) begin
      x = longint'($urandom_range(0, 131071));
      if (x >= 65536) x = x - 131072;
      m = int'($urandom_range(0, 3));
      run(0, m, x, res, ov, ed);
      model(m, x, 8, 32, mres, mov);
      checks++;
      if (res !== mres || ov !== mov) begin
        errors++;
        $display("FAIL random mode=%0d x=%0d result=%0d ovf=%0d required %0d ovf=%0d", m, x, res, ov, mres, mov);
      end
    end
  endtask

  task automatic test_ovf_clear();
    longint res, mres;
    bit     ov, mov;
    int     ed;
    run(1, 3, 65535, res, ov, ed);
    model(3, 65535, 8, 18, mres, mov);
    checks++;
    if (res !== 64'sd131071 || ov !== 1'b1 || mres !== 64'sd131071) begin
      errors++;
      $display("FAIL rw18_saturate result=%0d ovf=%0d required 131071 ovf=1", res, ov);
    end
    run(1, 3, 0, res, ov, ed);
    checks++;
    if (res !== 64'sd16384 || ov !== 1'b0) begin
      errors++;
      $display("FAIL rw18_ovf_clear result=%0d ovf=%0d required 16384 ovf=0", res, ov);
    end
  endtask

  task automatic test_back_to_back();
    longint mres;
    bit     mov, busy_seen = 0;
    int     dcount = 0, dcycle = -1;
    model(0, 8192, 8, 32, mres, mov);
    @(negedge clk);
    drive(0, 1, 0, 8192);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin dcount++; dcycle = c; end
      if (c == 1) busy_seen = busy0;
      if (c < 10) drive(0, 1, int'($urandom_range(0, 3)), longint'($urandom_range(0, 131071)));
      else drive(0, 0, 0, 0);
    end
    $display("txn back_to_back dones=%0d at_edge=%0d result=%0d", dcount, dcycle, result0);
    checks++;
    if (dcount !== 1 || dcycle !== 9) begin
      errors++;
      $display("FAIL back_to_back_dones count=%0d edge=%0d required 1 at edge 9", dcount, dcycle);
    end
    checks++;
    if (result0 !== mres[31:0] || busy_seen !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_result result=%0d busy=%b required %0d busy=1", result0, busy_seen, mres);
    end
  endtask

  task automatic test_reset_mid();
    longint res, mres, x;
    bit     ov, mov, stray = 0;
    int     ed;
    @(negedge clk);
    drive(0, 1, 1, 8192);
    @(posedge clk);
    #1 drive(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1;
    drive(0, 1, 2, 4096);
    @(posedge clk);
    #1;
    $display("txn reset_mid busy=%b done=%b result=%0d ovf=%b", busy0, done0, result0, ovf0);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 0 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%0d ovf=%b required all zero", busy0, done0, result0, ovf0);
    end
    @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0);
    repeat (12) begin
      @(posedge clk);
      #1 if (done0 || busy0) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_mid_idle busy/done seen after reset, required quiet");
    end
    x = 12000;
    run(0, 2, x, res, ov, ed);
    model(2, x, 8, 32, mres, mov);
    checks++;
    if (res !== mres || ov !== mov) begin
      errors++;
      $display("FAIL reset_mid_fresh result=%0d ovf=%0d required %0d ovf=%0d", res, ov, mres, mov);
    end
  endtask

  task automatic test_terms2();
    longint res, mres;
    bit     ov, mov;
    int     ed;
    run(2, 0, 8192, res, ov, ed);
    model(0, 8192, 2, 32, mres, mov);
    checks++;
    if (res !== 64'sd7509 || ov !== 1'b0 || mres !== 64'sd7509) begin
      errors++;
      $display("FAIL terms2_value result=%0d ovf=%0d required 7509 ovf=0", res, ov);
    end
    checks++;
    if (ed !== 3) begin
      errors++;
      $display("FAIL terms2_latency edges=%0d required 3", ed);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_zero_and_sign();
    test_random();
    test_ovf_clear();
    test_back_to_back();
    test_reset_mid();
    test_terms2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maclaurin_eval.md
# maclaurin_eval

Parametrised multi-function Maclaurin-series evaluator, the successor to the fixed-width, tanh-only evaluator. It computes tanh, sinh, sin or exp of a signed fixed-point operand by Horner evaluation over an internal per-mode coefficient ROM. Width, fraction bits and term count are set by parameters, and every step saturates with a sticky overflow flag. It sits behind the same start/done handshake as the series blocks it replaces, with a controller FSM and a multiply-accumulate datapath in one module.

## Interface
- XW, 17: operand and coefficient width, signed two's complement.
- FRAC, 14: fraction bits of x, coefficients, accumulator and result. Must satisfy FRAC < XW.
- RW, 32: accumulator and result width, signed. Must satisfy RW ≥ XW + 1.
- TERMS, 8: series terms used, range 2..8.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  function select: 0 tanh, 1 sinh, 2 sin, 3 exp. Captured with start.
- data_x  in  XW  operand x, Q(XW-FRAC).FRAC. Captured with start.
- busy  out  1  high in SQUARE, HORNER and FINAL.
- done  out  1  one-cycle pulse; result and ovf valid from this cycle.
- result  out  RW  f(x) in Q.FRAC; held until the next done.
- ovf  out  1  sticky saturation flag for the current evaluation; updated with done.

## Operation
- ROM C[mode][k], k = 0..7. Each entry is the exact rational rounded to nearest in Q.FRAC, XW bits. Only k < TERMS is used.
  - tanh: 1, -1/3, 2/15, -17/315, 62/2835, -1382/155925, 21844/6081075, -929569/638512875.
  - sinh: 1/(2k+1)!.
  - sin: (-1)^k/(2k+1)!.
  - exp: 1/k!.
- Odd modes (0..2): z = x², f = x·P(z). exp: z = x, f = P(z). P(z) = Σ C[k]·zᵏ.
- Product rule: mul(a,b) = (a·b) >>> FRAC, with the full-width product, arithmetic shift (floor), then saturation to RW signed. Coefficients are sign-extended before adding. Each add also saturates to RW. Any saturation event sets the internal sat bit.
- FSM states:
  - IDLE: on start=1, capture x and mode, set acc ← C[TERMS-1], k ← TERMS-2, clear sat. For exp, set z ← sext(x) and go to HORNER. For odd modes go to SQUARE.
  - SQUARE: z ← mul(x,x). Go to HORNER.
  - HORNER: acc ← mul(acc,z) + C[k], then k ← k-1. After the k=0 step: odd modes go to FINAL; exp goes to DONE, loading result ← new acc and ovf ← sat.
  - FINAL: result ← mul(acc,x), ovf ← sat including this step. Go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE, including in DONE, is ignored. There is no queueing. mode and data_x are don't-care outside the accept edge.
- rst wins over everything. At the next edge the state is IDLE and busy=0, done=0, result=0, ovf=0, with acc, z and sat cleared. start asserted on the same edge as rst is ignored.

## Timing
- Accept edge E0 is the edge that samples start=1 in IDLE.
- Odd modes: SQUARE after E0. HORNER updates on E1..E(TERMS-1). FINAL on E(TERMS). DONE is entered on edge E(TERMS+1), so done is high for the cycle after that edge. That is 9 edges for TERMS=8.
- exp: HORNER updates on E1..E(TERMS-1). DONE is entered on edge E(TERMS-1), which is 7 edges for TERMS=8.
- busy rises the cycle after E0 and falls when DONE is entered. Next earliest accept is on the edge leaving DONE+1, i.e. the first IDLE cycle.
- result and ovf change only on the edge entering DONE or on reset.

## Test plan
- Reset, then x=8192 (0.5) at defaults, checking result within ±4 LSB and ovf=0 in every case:
  - tanh: done after 9 edges, result 7571.
  - sinh: result 8538.
  - sin: result 7855.
  - exp: done after 7 edges, result 27013.
- x=0: odd modes give result=0 exactly. exp gives 16384 exactly. x=-8192 with tanh gives -7571 ±4, confirming sign symmetry.
- RW=18, exp, x=65535 (≈4.0) gives result=131071 and ovf=1. A following exp with x=0 gives 16384 and ovf=0, showing ovf is cleared per evaluation.
- Pulse start every cycle while busy with changing x and mode. Only the first request executes, and exactly one done pulse appears per accepted request.
- Assert rst mid-HORNER together with start. The next edge shows IDLE with all outputs 0 and no done. A fresh start then completes normally.
- TERMS=2, tanh, x=8192: done after 3 edges, result = mul(8192, 16384 + mul(C[1], 4096)), i.e. 0.5·(1 - 0.25/3) = 7509 in Q14.
